slice_adder_seq: RTL and testbench

- Parametrised multi-cycle ripple adder. Generalised, sequential successor to the 4-bit full adder.
- Computes sum = a + b + c_in on WIDTH-bit operands, processing one SLICE-bit slice per clock.
- A registered carry links the slices.
- Provides valid/ready handshakes on the input and output sides, plus carry-out and signed-overflow flags.
- Area-lean datapath arithmetic; typically instantiated below a stimulus or top module.

---
 rtl/slice_adder_seq.sv | 156 +++++++++++++++
 tb/tb_slice_adder_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_adder_seq.sv
// ---------------------------------------------------------------------------
// slice_adder_seq
//
// Multi-cycle ripple adder: sum = a + b + c_in on WIDTH-bit operands, adding
// one SLICE-bit slice per clock.  A registered carry links consecutive slices,
// so the adder logic is only SLICE+1 bits wide regardless of WIDTH.
//
// Ports
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   in_valid_i   operands valid             in_ready_o   block can accept operands
//   a_i, b_i     WIDTH-bit operands         c_in_i       carry-in
//   out_valid_o  result valid               out_ready_i  consumer takes result
//   sum_o        registered sum             c_out_o      unsigned carry-out
//   ovf_o        two's-complement overflow  busy_o       high in RUN or DONE
// ---------------------------------------------------------------------------
module slice_adder_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_in_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             c_out_o,
   output logic             ovf_o,
   output logic             busy_o
);

   // Guarded so an illegal SLICE cannot cause a divide-by-zero before the
   // parameter check below gets a chance to report it.
   localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] K_LAST = CW'(NSLICE - 1);

   generate
      if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_err
         $error("slice_adder_seq: illegal WIDTH=%0d / SLICE=%0d", WIDTH, SLICE);
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;

   // Current slice of the captured operands and their SLICE+1 bit sum.
   logic [SLICE-1:0] a_sl, b_sl;
   logic [SLICE:0]   slice_res;
   int               base;

   always_comb begin
      base      = int'(k_q) * SLICE;
      a_sl      = a_q[base +: SLICE];
      b_sl      = b_q[base +: SLICE];
      slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               carry_d = c_in_i;
               k_d     = '0;
               sum_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            sum_d[base +: SLICE] = slice_res[SLICE-1:0];
            carry_d              = slice_res[SLICE];
            if (k_q == K_LAST) begin
               // The top slice's MSB is the sum MSB, so overflow can be
               // decided here without reading sum_q back.
               c_out_d = slice_res[SLICE];
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (slice_res[SLICE-1] != a_q[WIDTH-1]);
               k_d     = '0;
               state_d = S_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake flags decode the state register only: no input-to-output path.
   assign in_ready_o  = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign sum_o       = sum_q;
   assign c_out_o     = c_out_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_slice_adder_seq.sv
// ---------------------------------------------------------------------------
// tb_slice_adder_seq
//
// Bench for slice_adder_seq.  A WIDTH=16/SLICE=4 instance runs the directed
// scenarios; three more instances (16/16, 16/1, 32/8) take random operands
// with random consumer backpressure.  Expected results are queued when
// operands are driven and popped when out_valid_o is seen.
// ---------------------------------------------------------------------------
module tb_slice_adder_seq;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Main 16/4 instance
   logic        in_valid, out_ready, ci;
   logic [15:0] a, b;
   logic        in_ready, out_valid, cout, ovf, busy;
   logic [15:0] sum;

   // Sweep instances: index 0 = 16/16, 1 = 16/1, 2 = 32/8
   logic        sv  [3];
   logic        sr  [3];
   logic        sci [3];
   logic [31:0] sa  [3];
   logic [31:0] sb  [3];
   logic        s_ir[3];
   logic        s_ov[3];
   logic        s_co[3];
   logic        s_of[3];
   logic        s_bz[3];
   logic [15:0] ss0, ss1;
   logic [31:0] ss2;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   slice_adder_seq #(.WIDTH(16), .SLICE(4)) u_dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .c_in_i(ci),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .sum_o(sum), .c_out_o(cout), .ovf_o(ovf), .busy_o(busy)
   );

   slice_adder_seq #(.WIDTH(16), .SLICE(16)) u_s16 (
      .clk_i(clk), .reset_n_i(rst_n),
      .in_valid_i(sv[0]), .in_ready_o(s_ir[0]),
      .a_i(sa[0][15:0]), .b_i(sb[0][15:0]), .c_in_i(sci[0]),
      .out_valid_o(s_ov[0]), .out_ready_i(sr[0]),
      .sum_o(ss0), .c_out_o(s_co[0]), .ovf_o(s_of[0]), .busy_o(s_bz[0])
   );

   slice_adder_seq #(.WIDTH(16), .SLICE(1)) u_s1 (
      .clk_i(clk), .reset_n_i(rst_n),
      .in_valid_i(sv[1]), .in_ready_o(s_ir[1]),
      .a_i(sa[1][15:0]), .b_i(sb[1][15:0]), .c_in_i(sci[1]),
      .out_valid_o(s_ov[1]), .out_ready_i(sr[1]),
      .sum_o(ss1), .c_out_o(s_co[1]), .ovf_o(s_of[1]), .busy_o(s_bz[1])
   );

   slice_adder_seq #(.WIDTH(32), .SLICE(8)) u_w32 (
      .clk_i(clk), .reset_n_i(rst_n),
      .in_valid_i(sv[2]), .in_ready_o(s_ir[2]),
      .a_i(sa[2]), .b_i(sb[2]), .c_in_i(sci[2]),
      .out_valid_o(s_ov[2]), .out_ready_i(sr[2]),
      .sum_o(ss2), .c_out_o(s_co[2]), .ovf_o(s_of[2]), .busy_o(s_bz[2])
   );

   // Reference: full-precision add, then derive carry and signed overflow.
   function automatic exp_t ref_add(input logic [31:0] x, input logic [31:0] y,
                                    input logic c, input int w);
      logic [32:0] full;
      exp_t        e;
      full = {1'b0, x} + {1'b0, y} + {32'b0, c};
      if (w == 16) begin
         e.sum  = {16'b0, full[15:0]};
         e.cout = full[16];
         e.ovf  = (x[15] == y[15]) && (full[15] != x[15]);
      end else begin
         e.sum  = full[31:0];
         e.cout = full[32];
         e.ovf  = (x[31] == y[31]) && (full[31] != x[31]);
      end
      return e;
   endfunction

   function automatic int sw_width(input int idx);
      return (idx == 2) ? 32 : 16;
   endfunction

   function automatic int sw_nslice(input int idx);
      case (idx)
         0:       return 1;
         1:       return 16;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] sw_sum(input int idx);
      case (idx)
         0:       return {16'b0, ss0};
         1:       return {16'b0, ss1};
         default: return ss2;
      endcase
   endfunction

   // Drive one operand set into the main instance; called at a negedge.
   // Returns at the negedge after the accepting edge.
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                       input exp_t e);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      a        = x;
      b        = y;
      ci       = c;
      in_valid = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count edges after acceptance until out_valid is seen (bounded).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ci        = 1'b0;
      a         = '0;
      b         = '0;
      for (int i = 0; i < 3; i++) begin
         sv[i] = 1'b0; sr[i] = 1'b0; sci[i] = 1'b0; sa[i] = '0; sb[i] = '0;
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if ({in_ready, out_valid, busy, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL reset_state: rdy=%b vld=%b busy=%b co=%b ovf=%b sum=%h required 1 0 0 0 0 0000",
                  in_ready, out_valid, busy, cout, ovf, sum);
      end
      n_vec++;
      if ({s_ir[0], s_ir[1], s_ir[2], s_bz[0], s_bz[1], s_bz[2], s_ov[0], s_ov[1], s_ov[2]} !== 9'b111_000_000) begin
         n_err++;
         $display("FAIL reset_sweep_flags: ready/busy/valid not idle after reset");
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: rdy=%b vld=%b busy=%b sum=%h", in_ready, out_valid, busy, sum);
   endtask

   task automatic test_basic();
      int   lat;
      exp_t e;
      send(16'h1234, 16'h4321, 1'b0, '{32'h5555, 1'b0, 1'b0});
      n_vec++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
         n_err++;
         $display("FAIL basic_busy: busy=%b rdy=%b vld=%b required 1 0 0", busy, in_ready, out_valid);
      end
      wait_valid(lat);
      e = sb_q.pop_front();
      n_vec++;
      if (sum !== e.sum[15:0] || cout !== e.cout || ovf !== e.ovf || lat != 4) begin
         n_err++;
         $display("FAIL basic_result: sum=%h co=%b ovf=%b lat=%0d required %h %b %b 4",
                  sum, cout, ovf, lat, e.sum[15:0], e.cout, e.ovf);
      end
      $display("basic: a=1234 b=4321 ci=0 -> sum=%h co=%b ovf=%b lat=%0d", sum, cout, ovf, lat);
      consume();
      n_vec++;
      if ({in_ready, out_valid, busy} !== 3'b100 || sum !== 16'h5555) begin
         n_err++;
         $display("FAIL basic_release: rdy=%b vld=%b busy=%b sum=%h required 1 0 0 5555",
                  in_ready, out_valid, busy, sum);
      end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] xa[3];
      logic [15:0] xb[3];
      logic        xc[3];
      exp_t        xe[3];
      exp_t        e;
      int          lat;
      xa[0] = 16'hFFFF; xb[0] = 16'h0000; xc[0] = 1'b1; xe[0] = '{32'h0000, 1'b1, 1'b0};
      xa[1] = 16'h7FFF; xb[1] = 16'h0001; xc[1] = 1'b0; xe[1] = '{32'h8000, 1'b0, 1'b1};
      xa[2] = 16'h8000; xb[2] = 16'h8000; xc[2] = 1'b0; xe[2] = '{32'h0000, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         send(xa[i], xb[i], xc[i], xe[i]);
         wait_valid(lat);
         e = sb_q.pop_front();
         n_vec++;
         if (sum !== e.sum[15:0] || cout !== e.cout || ovf !== e.ovf || lat != 4) begin
            n_err++;
            $display("FAIL ripple_%0d: sum=%h co=%b ovf=%b lat=%0d required %h %b %b 4",
                     i, sum, cout, ovf, lat, e.sum[15:0], e.cout, e.ovf);
         end
         $display("ripple: a=%h b=%h ci=%b -> sum=%h co=%b ovf=%b lat=%0d",
                  xa[i], xb[i], xc[i], sum, cout, ovf, lat);
         consume();
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      send(16'h00AA, 16'h0055, 1'b0, '{32'h00FF, 1'b0, 1'b0});
      wait_valid(lat);
      e = sb_q.pop_front();
      n_vec++;
      if (sum !== e.sum[15:0] || cout !== e.cout || ovf !== e.ovf || lat != 4) begin
         n_err++;
         $display("FAIL bp_first: sum=%h co=%b ovf=%b lat=%0d required %h %b %b 4",
                  sum, cout, ovf, lat, e.sum[15:0], e.cout, e.ovf);
      end
      // Upstream presents the next operands while the result is held.
      a = 16'h0001; b = 16'h0001; ci = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (sum !== 16'h00FF || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold_%0d: sum=%h co=%b ovf=%b rdy=%b vld=%b required 00ff 0 0 0 1",
                     i, sum, cout, ovf, in_ready, out_valid);
         end
      end
      $display("backpressure: held sum=%h for 6 cycles", sum);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_ready: rdy=%b required 1", in_ready);
      end
      sb_q.push_back('{32'h0002, 1'b0, 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(lat);
      e = sb_q.pop_front();
      n_vec++;
      if (sum !== e.sum[15:0] || cout !== e.cout || ovf !== e.ovf || lat != 4) begin
         n_err++;
         $display("FAIL bp_second: sum=%h co=%b ovf=%b lat=%0d required %h %b %b 4",
                  sum, cout, ovf, lat, e.sum[15:0], e.cout, e.ovf);
      end
      $display("backpressure: a=0001 b=0001 -> sum=%h lat=%0d", sum, lat);
      consume();
   endtask

   task automatic test_mid_reset();
      exp_t e;
      int   lat;
      send(16'h1234, 16'h1111, 1'b0, '{32'h2345, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      // Two slices done: 0x4 + 0x1 and 0x3 + 0x1.
      n_vec++;
      if (sum !== 16'h0045 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_partial: sum=%h busy=%b required 0045 1", sum, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({out_valid, busy, cout, sum, in_ready} !== {1'b0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
         n_err++;
         $display("FAIL midrst_async: vld=%b busy=%b co=%b sum=%h rdy=%b required 0 0 0 0000 1",
                  out_valid, busy, cout, sum, in_ready);
      end
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("midreset: cleared, rdy=%b", in_ready);
      send(16'h00FF, 16'h0001, 1'b0, '{32'h0100, 1'b0, 1'b0});
      wait_valid(lat);
      e = sb_q.pop_front();
      n_vec++;
      if (sum !== e.sum[15:0] || cout !== e.cout || ovf !== e.ovf || lat != 4) begin
         n_err++;
         $display("FAIL midrst_fresh: sum=%h co=%b ovf=%b lat=%0d required %h %b %b 4",
                  sum, cout, ovf, lat, e.sum[15:0], e.cout, e.ovf);
      end
      $display("midreset: a=00ff b=0001 -> sum=%h lat=%0d", sum, lat);
      consume();
   endtask

   task automatic test_sweep(input int idx);
      int          w, ns, t, lat;
      logic [31:0] x, y;
      logic        c;
      exp_t        e;
      w  = sw_width(idx);
      ns = sw_nslice(idx);
      for (int n = 0; n < 1000; n++) begin
         x = $urandom;
         y = $urandom;
         c = 1'($urandom_range(0, 1));
         if (w == 16) begin
            x = {16'b0, x[15:0]};
            y = {16'b0, y[15:0]};
         end
         t = 0;
         while (!s_ir[idx] && t < 100) begin
            @(negedge clk);
            t++;
         end
         sa[idx] = x; sb[idx] = y; sci[idx] = c; sv[idx] = 1'b1;
         sb_q.push_back(ref_add(x, y, c, w));
         @(negedge clk);
         sv[idx] = 1'b0;
         lat = 0;
         while (!s_ov[idx] && lat < 60) begin
            @(negedge clk);
            lat++;
         end
         e = sb_q.pop_front();
         n_vec++;
         if (sw_sum(idx) !== e.sum || s_co[idx] !== e.cout || s_of[idx] !== e.ovf || lat != ns) begin
            n_err++;
            $display("FAIL sweep%0d_op%0d: sum=%h co=%b ovf=%b lat=%0d required %h %b %b %0d",
                     idx, n, sw_sum(idx), s_co[idx], s_of[idx], lat, e.sum, e.cout, e.ovf, ns);
         end
         $display("sweep%0d op%0d: a=%h b=%h ci=%b -> sum=%h co=%b ovf=%b lat=%0d",
                  idx, n, x, y, c, sw_sum(idx), s_co[idx], s_of[idx], lat);
         t = 0;
         while (s_ov[idx] && t < 60) begin
            sr[idx] = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
            if (s_ov[idx]) begin
               n_vec++;
               if (sw_sum(idx) !== e.sum) begin
                  n_err++;
                  $display("FAIL sweep%0d_hold%0d: sum=%h required %h", idx, n, sw_sum(idx), e.sum);
               end
            end
         end
         sr[idx] = 1'b0;
         if (s_ov[idx]) begin
            n_vec++;
            n_err++;
            $display("FAIL sweep%0d_drain_timeout: vld=%b required 0", idx, s_ov[idx]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_backpressure();
      test_mid_reset();
      test_sweep(0);
      test_sweep(1);
      test_sweep(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
